// File: rtl/airlock_sequencer.sv
// Airlock door/pump sequencer: walks an occupant through evacuation, pressurisation
// and door cycles, driving an external countdown timer and faulting on a door breach.
module airlock_sequencer #(
    parameter logic [9:0] EVAC_SECS  = 10'd480,
    parameter logic [9:0] PRESS_SECS = 10'd420
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       outer_closed,
    input  logic       inner_closed,
    input  logic       tmr_done,
    output logic       tmr_start,
    output logic [9:0] tmr_secs,
    output logic       outer_unlock,
    output logic       inner_unlock,
    output logic       pump_evac,
    output logic       pump_press,
    output logic       chamber_press,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_EVAC  = 3'd1,
        ST_PRESS = 3'd2,
        ST_OUTER = 3'd3,
        ST_INNER = 3'd4,
        ST_FAULT = 3'd7
    } state_t;

    state_t     state_reg, state_next;
    logic       dir_reg, dir_next;
    logic       press_reg, press_next;
    logic [1:0] guard_reg, guard_next;
    logic       seen_open_reg, seen_open_next;
    logic [9:0] secs_reg, secs_next;
    logic       start_next;

    logic       start_reg;
    logic       outer_unlock_reg, inner_unlock_reg;
    logic       pump_evac_reg, pump_press_reg;
    logic       busy_reg, fault_reg;

    always_comb begin
        state_next     = state_reg;
        dir_next       = dir_reg;
        press_next     = press_reg;
        guard_next     = guard_reg;
        seen_open_next = seen_open_reg;
        secs_next      = secs_reg;
        start_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (depart_req) begin
                    dir_next   = 1'b1;
                    state_next = press_reg ? ST_INNER : ST_PRESS;
                end else if (arrive_req) begin
                    dir_next   = 1'b0;
                    state_next = press_reg ? ST_EVAC : ST_OUTER;
                end
            end
            ST_EVAC, ST_PRESS: begin
                // tmr_done still reflects the previous count until the load lands
                if (!outer_closed || !inner_closed) begin
                    state_next = ST_FAULT;
                end else if (guard_reg != 2'd3) begin
                    guard_next = guard_reg + 2'd1;
                end else if (tmr_done) begin
                    if (state_reg == ST_EVAC) begin
                        press_next = 1'b0;
                        state_next = ST_OUTER;
                    end else begin
                        press_next = 1'b1;
                        state_next = ST_INNER;
                    end
                end
            end
            ST_OUTER: begin
                if (!seen_open_reg) begin
                    if (!outer_closed) seen_open_next = 1'b1;
                end else if (outer_closed) begin
                    state_next = dir_reg ? ST_IDLE : ST_PRESS;
                end
            end
            ST_INNER: begin
                if (!seen_open_reg) begin
                    if (!inner_closed) seen_open_next = 1'b1;
                end else if (inner_closed) begin
                    state_next = dir_reg ? ST_EVAC : ST_IDLE;
                end
            end
            ST_FAULT: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
        endcase

        // Every state entry restarts the guard and door tracking; only pump states load the timer
        if (state_next != state_reg) begin
            guard_next     = 2'd0;
            seen_open_next = 1'b0;
            if (state_next == ST_EVAC) begin
                start_next = 1'b1;
                secs_next  = EVAC_SECS;
            end else if (state_next == ST_PRESS) begin
                start_next = 1'b1;
                secs_next  = PRESS_SECS;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg        <= ST_IDLE;
            dir_reg          <= 1'b0;
            press_reg        <= 1'b1;
            guard_reg        <= 2'd0;
            seen_open_reg    <= 1'b0;
            secs_reg         <= 10'd0;
            start_reg        <= 1'b0;
            outer_unlock_reg <= 1'b0;
            inner_unlock_reg <= 1'b0;
            pump_evac_reg    <= 1'b0;
            pump_press_reg   <= 1'b0;
            busy_reg         <= 1'b0;
            fault_reg        <= 1'b0;
        end else begin
            state_reg        <= state_next;
            dir_reg          <= dir_next;
            press_reg        <= press_next;
            guard_reg        <= guard_next;
            seen_open_reg    <= seen_open_next;
            secs_reg         <= secs_next;
            start_reg        <= start_next;
            outer_unlock_reg <= (state_next == ST_OUTER) && !seen_open_next;
            inner_unlock_reg <= (state_next == ST_INNER) && !seen_open_next;
            pump_evac_reg    <= (state_next == ST_EVAC);
            pump_press_reg   <= (state_next == ST_PRESS);
            busy_reg         <= (state_next != ST_IDLE);
            fault_reg        <= (state_next == ST_FAULT);
        end
    end

    assign tmr_start     = start_reg;
    assign tmr_secs      = secs_reg;
    assign outer_unlock  = outer_unlock_reg;
    assign inner_unlock  = inner_unlock_reg;
    assign pump_evac     = pump_evac_reg;
    assign pump_press    = pump_press_reg;
    assign chamber_press = press_reg;
    assign busy          = busy_reg;
    assign fault         = fault_reg;
    assign state         = state_reg;

endmodule

// File: doc/airlock_sequencer.md
AIRLOCK_SEQUENCER -- requirements
Module: airlock_sequencer

Interface
REQ-001 The block SHALL take parameter EVAC_SECS, default 480 (10 bits), as the seconds loaded into the countdown timer for chamber evacuation.
REQ-002 The block SHALL take parameter PRESS_SECS, default 420 (10 bits), as the seconds loaded into the countdown timer for chamber pressurisation.
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 arrive_req  input  1  level; occupant outside requests entry.
REQ-006 depart_req  input  1  level; occupant inside requests exit.
REQ-007 outer_closed  input  1  1 = outer door closed.
REQ-008 inner_closed  input  1  1 = inner door closed.
REQ-009 tmr_done  input  1  countdown timer terminal flag (1 while count is 0).
REQ-010 tmr_start  output  1  one-cycle pulse that loads and starts the countdown timer.
REQ-011 tmr_secs  output  10  value presented to the timer; valid whenever tmr_start=1.
REQ-012 outer_unlock / inner_unlock  output  1 each  door release enables.
REQ-013 pump_evac / pump_press  output  1 each  pump drives.
REQ-014 chamber_press  output  1  1 = chamber at interior pressure.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 fault  output  1  high only in FAULT.
REQ-017 state  output  3  encoding: IDLE=0, EVAC=1, PRESS=2, OUTER=3, INNER=4, FAULT=7.

Function
REQ-018 All outputs SHALL be registered; each SHALL change on the clk edge that enters or leaves the state that drives it.
REQ-019 A direction register dir (0 = entering, 1 = exiting) SHALL be latched when IDLE is left.
REQ-020 IDLE with depart_req=1 SHALL have priority over arrive_req: dir=1, then INNER if chamber_press=1, else PRESS.
REQ-021 IDLE with arrive_req=1 and depart_req=0: dir=0, then EVAC if chamber_press=1, else OUTER.
REQ-022 On entry to EVAC or PRESS the block SHALL assert tmr_start for exactly one cycle, with tmr_secs=EVAC_SECS or PRESS_SECS respectively.
REQ-023 In EVAC/PRESS, tmr_done SHALL be ignored for the first 3 cycles in the state (timer load latency guard); after that, tmr_done=1 ends the state.
REQ-024 pump_evac SHALL be 1 only in EVAC; pump_press SHALL be 1 only in PRESS; the two SHALL never both be 1.
REQ-025 EVAC completion SHALL clear chamber_press and go to OUTER.
REQ-026 PRESS completion SHALL set chamber_press; then go to INNER if dir=0, or OUTER... not applicable, so: if dir=1 PRESS is only reached with chamber evacuated and SHALL go to INNER.
REQ-027 OUTER/INNER SHALL hold the matching unlock at 1 until that door has been seen open (closed=0) and then closed (closed=1); the unlock SHALL drop on the first open sample.
REQ-028 OUTER exit: dir=0 goes to PRESS; dir=1 goes to IDLE.
REQ-029 INNER exit: dir=0 goes to IDLE; dir=1 goes to EVAC.
REQ-030 Both unlocks SHALL never be 1 simultaneously, and both SHALL be 0 outside OUTER/INNER.
REQ-031 Either door open (closed=0) while in EVAC or PRESS SHALL enter FAULT next cycle: pumps off, unlocks 0, tmr_start 0; FAULT is left only by reset.
REQ-032 Requests arriving while busy=1 SHALL be ignored and not queued; after returning to IDLE, levels still high SHALL be served.
REQ-033 No further tmr_start SHALL be issued while the timer is running; the timer SHALL not be restarted mid-count.

Reset
REQ-034 reset=0 at any clk edge SHALL force: state=IDLE, chamber_press=1, dir=0, all other outputs 0, guard count 0, door-seen-open flag 0; this SHALL apply mid-sequence, including from FAULT.

Verification (EVAC_SECS=3, PRESS_SECS=2, timer model with 1-cycle seconds)
REQ-035 Entry: reset, then arrive_req pulse -> EVAC with tmr_start=1 and tmr_secs=3; after tmr_done, outer_unlock=1; cycle the outer door -> PRESS with tmr_secs=2 -> inner_unlock; cycle the inner door -> IDLE with chamber_press=1.
REQ-036 Exit from pressurised chamber: depart_req -> INNER, then EVAC, then OUTER -> IDLE with chamber_press=0; a following arrive_req -> OUTER directly (no EVAC).
REQ-037 Simultaneous arrive_req=depart_req=1 in IDLE -> dir=1 and state=INNER.
REQ-038 Stale tmr_done=1 held during the first 3 EVAC cycles -> state stays EVAC.
REQ-039 outer_closed=0 during PRESS -> FAULT next cycle with fault=1 and pumps 0; requests ignored; reset=0 -> IDLE with chamber_press=1.
REQ-040 reset asserted mid-EVAC -> next cycle all outputs at reset values; no tmr_start is issued until a new request arrives.
